// File: rtl/motor_pwm_pkg.sv
// Shared definitions for the motor PWM scheduler: state encoding and register map.
package motor_pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [2:0] ADDR_PERIOD    = 3'd0;
  localparam logic [2:0] ADDR_DEADBAND  = 3'd1;
  localparam logic [2:0] ADDR_DUTY_A    = 3'd2;
  localparam logic [2:0] ADDR_DUTY_B    = 3'd3;
  localparam logic [2:0] ADDR_DUTY_C    = 3'd4;
  localparam logic [2:0] ADDR_RAMP_STEP = 3'd5;
  localparam logic [2:0] ADDR_CTRL      = 3'd6;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int CTRL_FCLR_BIT = 1;

endpackage

// File: rtl/motor_pwm_ramp.sv
// One channel of the soft-start ramp: moves cur toward target by step, never overshooting.
// Combinational; a step of zero jumps straight to the target.
module motor_pwm_ramp #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] cur,
  input  logic [SIZE-1:0] target,
  input  logic [SIZE-1:0] step,
  output logic [SIZE-1:0] nxt
);

  logic [SIZE:0] up_sum;
  logic [SIZE:0] down_gap;

  // One extra bit so cur+step cannot wrap past the target.
  assign up_sum   = {1'b0, cur} + {1'b0, step};
  assign down_gap = {1'b0, cur} - {1'b0, target};

  always_comb begin
    nxt = cur;
    if (step == '0) begin
      nxt = target;
    end else if (cur < target) begin
      nxt = (up_sum >= {1'b0, target}) ? target : up_sum[SIZE-1:0];
    end else if (cur > target) begin
      nxt = (down_gap <= {1'b0, step}) ? target : cur - step;
    end
  end

endmodule

// File: rtl/motor_pwm_sched.sv
// Three-phase PWM parameter scheduler: shadow registers, soft-start ramp and fault latch.
// Active values only change on iSYNC (or on arm/stop/fault), one cycle after the event.
module motor_pwm_sched
  import motor_pwm_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iWR,
  input  logic [2:0]      iADDR,
  input  logic [SIZE-1:0] iDATA,
  input  logic            iSYNC,
  input  logic            iFAULT_N,
  output logic            oENABLE,
  output logic [SIZE-1:0] oPERIOD,
  output logic [SIZE-1:0] oDEADBAND,
  output logic [SIZE-1:0] oDUTY_A,
  output logic [SIZE-1:0] oDUTY_B,
  output logic [SIZE-1:0] oDUTY_C,
  output logic [2:0]      oSTATE,
  output logic            oFAULT,
  output logic            oPENDING
);

  state_t          state, state_nxt;
  logic [SIZE-1:0] sh_period, sh_deadband, ramp_step;
  logic [SIZE-1:0] sh_duty  [3];
  logic [SIZE-1:0] period, deadband;
  logic [SIZE-1:0] duty     [3];
  logic [SIZE-1:0] tgt      [3];
  logic [SIZE-1:0] duty_nxt [3];
  logic            pending, fault, enable;

  // A write in the same cycle as a fault is dropped: fault wins.
  logic wr_ok, ctrl_wr, run_set, run_clr, fault_clr, all_done, arm_load, run_load;
  assign wr_ok     = iWR && iFAULT_N;
  assign ctrl_wr   = wr_ok && (iADDR == ADDR_CTRL);
  assign run_set   = ctrl_wr && iDATA[CTRL_RUN_BIT];
  assign run_clr   = ctrl_wr && !iDATA[CTRL_RUN_BIT];
  assign fault_clr = ctrl_wr && iDATA[CTRL_FCLR_BIT];

  for (genvar g = 0; g < 3; g++) begin : g_ch
    assign tgt[g] = (sh_duty[g] > period) ? period : sh_duty[g];
    motor_pwm_ramp #(.SIZE(SIZE)) u_ramp (
      .cur    (duty[g]),
      .target (tgt[g]),
      .step   (ramp_step),
      .nxt    (duty_nxt[g])
    );
  end

  assign all_done = (duty_nxt[0] == tgt[0]) && (duty_nxt[1] == tgt[1]) && (duty_nxt[2] == tgt[2]);

  always_comb begin
    state_nxt = state;
    if (!iFAULT_N) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE:  if (run_set) state_nxt = ST_ARMED;
        ST_ARMED: if (run_clr) state_nxt = ST_IDLE; else if (iSYNC) state_nxt = ST_RAMP;
        ST_RAMP:  if (run_clr) state_nxt = ST_IDLE; else if (iSYNC && all_done) state_nxt = ST_RUN;
        ST_RUN:   if (run_clr) state_nxt = ST_IDLE;
        ST_FAULT: if (fault_clr) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign arm_load = (state == ST_IDLE) && (state_nxt == ST_ARMED);
  assign run_load = (state == ST_RUN) && (state_nxt == ST_RUN) && iSYNC && pending;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sh_period   <= '0;
      sh_deadband <= '0;
      ramp_step   <= '0;
      sh_duty     <= '{default: '0};
      period      <= '0;
      deadband    <= '0;
      duty        <= '{default: '0};
      pending     <= 1'b0;
      fault       <= 1'b0;
      enable      <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (iADDR)
          ADDR_PERIOD:    sh_period   <= iDATA;
          ADDR_DEADBAND:  sh_deadband <= iDATA;
          ADDR_DUTY_A:    sh_duty[0]  <= iDATA;
          ADDR_DUTY_B:    sh_duty[1]  <= iDATA;
          ADDR_DUTY_C:    sh_duty[2]  <= iDATA;
          ADDR_RAMP_STEP: ramp_step   <= iDATA;
          default: ;
        endcase
      end

      // A shadow write landing with a load keeps PENDING for the next iSYNC.
      if (wr_ok && (iADDR <= ADDR_RAMP_STEP)) pending <= 1'b1;
      else if (arm_load || run_load)          pending <= 1'b0;

      if (arm_load || run_load) begin
        period   <= sh_period;
        deadband <= sh_deadband;
      end

      if (state_nxt == ST_IDLE || state_nxt == ST_ARMED || state_nxt == ST_FAULT) begin
        duty <= '{default: '0};
      end else if (state == ST_RAMP && iSYNC) begin
        duty <= duty_nxt;
      end else if (run_load) begin
        for (int i = 0; i < 3; i++) duty[i] <= (sh_duty[i] > sh_period) ? sh_period : sh_duty[i];
      end

      if (!iFAULT_N)                           fault <= 1'b1;
      else if (state == ST_FAULT && fault_clr) fault <= 1'b0;

      enable <= (state_nxt == ST_ARMED) || (state_nxt == ST_RAMP) || (state_nxt == ST_RUN);
    end
  end

  assign oENABLE   = enable;
  assign oPERIOD   = period;
  assign oDEADBAND = deadband;
  assign oDUTY_A   = duty[0];
  assign oDUTY_B   = duty[1];
  assign oDUTY_C   = duty[2];
  assign oSTATE    = state;
  assign oFAULT    = fault;
  assign oPENDING  = pending;

endmodule

// File: tb/tb_motor_pwm_sched.sv
// Bench for motor_pwm_sched: directed scenarios plus random traffic against a behavioural model.
module tb_motor_pwm_sched;

  localparam int SIZE = 16;

  logic            iCLK = 1'b0;
  logic            iRST_N;
  logic            iWR;
  logic [2:0]      iADDR;
  logic [SIZE-1:0] iDATA;
  logic            iSYNC;
  logic            iFAULT_N;
  logic            oENABLE, oFAULT, oPENDING;
  logic [SIZE-1:0] oPERIOD, oDEADBAND, oDUTY_A, oDUTY_B, oDUTY_C;
  logic [2:0]      oSTATE;

  int checks = 0;
  int errors = 0;

  // Model state, in the spec's own terms: 0 IDLE 1 ARMED 2 RAMP 3 RUN 4 FAULT.
  int m_state, m_period, m_deadband, m_step, m_pend, m_fault, m_en;
  int m_sh_period, m_sh_deadband;
  int m_sh_duty [3];
  int m_duty    [3];

  motor_pwm_sched #(.SIZE(SIZE)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iWR(iWR), .iADDR(iADDR), .iDATA(iDATA),
    .iSYNC(iSYNC), .iFAULT_N(iFAULT_N), .oENABLE(oENABLE), .oPERIOD(oPERIOD),
    .oDEADBAND(oDEADBAND), .oDUTY_A(oDUTY_A), .oDUTY_B(oDUTY_B), .oDUTY_C(oDUTY_C),
    .oSTATE(oSTATE), .oFAULT(oFAULT), .oPENDING(oPENDING)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic m_reset();
    m_state = 0; m_period = 0; m_deadband = 0; m_step = 0; m_pend = 0;
    m_fault = 0; m_en = 0; m_sh_period = 0; m_sh_deadband = 0;
    for (int i = 0; i < 3; i++) begin m_sh_duty[i] = 0; m_duty[i] = 0; end
  endtask

  task automatic m_cycle(input bit wr, input int addr, input int data, input bit sync, input bit fault_n);
    bit ctrl, done;
    int tg, st;
    ctrl = wr && addr == 6;
    if (!fault_n) begin
      m_state = 4; m_fault = 1;
    end else begin
      case (m_state)
        0: if (ctrl && data[0]) begin
             m_period = m_sh_period; m_deadband = m_sh_deadband; m_pend = 0; m_state = 1;
           end
        1: if (ctrl && !data[0]) m_state = 0; else if (sync) m_state = 2;
        2: if (ctrl && !data[0]) m_state = 0;
           else if (sync) begin
             done = 1;
             for (int i = 0; i < 3; i++) begin
               tg = imin(m_sh_duty[i], m_period);
               st = (m_step == 0) ? 1 << 20 : m_step;
               m_duty[i] = (m_duty[i] < tg) ? imin(m_duty[i] + st, tg) : imax(m_duty[i] - st, tg);
               if (m_duty[i] != tg) done = 0;
             end
             if (done) m_state = 3;
           end
        3: if (ctrl && !data[0]) m_state = 0;
           else if (sync && m_pend != 0) begin
             m_period = m_sh_period; m_deadband = m_sh_deadband; m_pend = 0;
             for (int i = 0; i < 3; i++) m_duty[i] = imin(m_sh_duty[i], m_sh_period);
           end
        default: if (ctrl && data[1]) begin m_state = 0; m_fault = 0; end
      endcase
      if (wr && addr <= 5) begin
        m_pend = 1;
        case (addr)
          0: m_sh_period = data;
          1: m_sh_deadband = data;
          2: m_sh_duty[0] = data;
          3: m_sh_duty[1] = data;
          4: m_sh_duty[2] = data;
          default: m_step = data;
        endcase
      end
    end
    if (m_state == 0 || m_state == 1 || m_state == 4)
      for (int i = 0; i < 3; i++) m_duty[i] = 0;
    m_en = (m_state >= 1 && m_state <= 3) ? 1 : 0;
  endtask

  task automatic check_model();
    chk("state",    32'(oSTATE),    32'(m_state));
    chk("enable",   32'(oENABLE),   32'(m_en));
    chk("period",   32'(oPERIOD),   32'(m_period));
    chk("deadband", 32'(oDEADBAND), 32'(m_deadband));
    chk("duty_a",   32'(oDUTY_A),   32'(m_duty[0]));
    chk("duty_b",   32'(oDUTY_B),   32'(m_duty[1]));
    chk("duty_c",   32'(oDUTY_C),   32'(m_duty[2]));
    chk("fault",    32'(oFAULT),    32'(m_fault));
    chk("pending",  32'(oPENDING),  32'(m_pend));
  endtask

  task automatic cyc(input bit wr, input int addr, input int data, input bit sync, input bit fault_n);
    @(negedge iCLK);
    iWR = wr; iADDR = 3'(addr); iDATA = SIZE'(data); iSYNC = sync; iFAULT_N = fault_n;
    @(posedge iCLK);
    m_cycle(wr, addr, data, sync, fault_n);
    #1;
    check_model();
  endtask

  task automatic wr(input int addr, input int data);
    cyc(1'b1, addr, data, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic sync();
    cyc(1'b0, 0, 0, 1'b1, 1'b1);
  endtask

  initial begin
    iRST_N = 1'b0; iWR = 1'b0; iADDR = '0; iDATA = '0; iSYNC = 1'b0; iFAULT_N = 1'b1;
    m_reset();
    #12;
    check_model();
    @(negedge iCLK) iRST_N = 1'b1;

    // Soft start 40/60/100 with step 20 under period 100.
    wr(0, 100); wr(2, 40); wr(3, 60); wr(4, 100); wr(5, 20);
    chk("pend_after_wr", 32'(oPENDING), 1);
    wr(6, 1);
    chk("armed", 32'(oSTATE), 1);
    chk("armed_en", 32'(oENABLE), 1);
    chk("armed_period", 32'(oPERIOD), 100);
    idle(); idle();
    sync();
    chk("ramp_entry", 32'(oSTATE), 2);
    for (int k = 1; k <= 5; k++) begin
      idle();
      sync();
      chk("ramp_a", 32'(oDUTY_A), 32'(imin(20 * k, 40)));
      chk("ramp_b", 32'(oDUTY_B), 32'(imin(20 * k, 60)));
      chk("ramp_c", 32'(oDUTY_C), 32'(20 * k));
      chk("ramp_state", 32'(oSTATE), (k == 5) ? 3 : 2);
    end

    // Mid-period duty write waits for the next iSYNC.
    wr(2, 70); idle();
    chk("dutya_hold", 32'(oDUTY_A), 40);
    sync();
    chk("dutya_load", 32'(oDUTY_A), 70);

    // Write colliding with iSYNC: old shadow loads, new value stays pending.
    wr(2, 30);
    cyc(1'b1, 3, 50, 1'b1, 1'b1);
    chk("coll_a", 32'(oDUTY_A), 30);
    chk("coll_b", 32'(oDUTY_B), 60);
    chk("coll_pend", 32'(oPENDING), 1);
    sync();
    chk("coll_b_next", 32'(oDUTY_B), 50);

    // Duty above period clamps.
    wr(3, 150); sync();
    chk("clamp_b", 32'(oDUTY_B), 100);

    wr(6, 0);
    chk("stop_state", 32'(oSTATE), 0);
    chk("stop_duty_c", 32'(oDUTY_C), 0);

    // Fault during RAMP, clear ignored while fault held.
    wr(6, 1); sync(); sync();
    chk("ramp_again", 32'(oDUTY_A), 20);
    cyc(1'b0, 0, 0, 1'b0, 1'b0);
    chk("flt_state", 32'(oSTATE), 4);
    chk("flt_en", 32'(oENABLE), 0);
    chk("flt_duty_a", 32'(oDUTY_A), 0);
    chk("flt_flag", 32'(oFAULT), 1);
    cyc(1'b1, 6, 2, 1'b0, 1'b0);
    chk("flt_clr_low", 32'(oSTATE), 4);
    cyc(1'b1, 6, 2, 1'b0, 1'b1);
    chk("flt_clr_high", 32'(oSTATE), 0);
    chk("flt_flag_clr", 32'(oFAULT), 0);

    // Reach RUN then reset mid-cycle.
    wr(6, 1); sync();
    for (int k = 0; k < 6; k++) sync();
    chk("run_before_rst", 32'(oSTATE), 3);
    #2 iRST_N = 1'b0;
    #1;
    m_reset();
    chk("rst_async_en", 32'(oENABLE), 0);
    chk("rst_async_duty_b", 32'(oDUTY_B), 0);
    check_model();
    @(negedge iCLK) iRST_N = 1'b1;

    // Ramp step zero jumps straight to the targets.
    wr(0, 80); wr(2, 10); wr(3, 90); wr(4, 80); wr(6, 1);
    sync(); sync();
    chk("step0_state", 32'(oSTATE), 3);
    chk("step0_b", 32'(oDUTY_B), 80);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int r, a, d;
      bit w, s, f;
      r = $urandom_range(0, 99);
      w = (r < 30);
      a = $urandom_range(0, 7);
      if (a == 6) d = $urandom_range(0, 3);
      else if (a == 5) d = $urandom_range(0, 40);
      else d = $urandom_range(0, 200);
      s = ($urandom_range(0, 6) == 0);
      f = ($urandom_range(0, 59) != 0);
      cyc(w, a, d, s, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_sched.md
MOTOR_PWM_SCHED -- requirements
Module: motor_pwm_sched

Interface
REQ-001 Parameter SIZE, default 16: width of period, deadband, duty and ramp-step values.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 iCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 iRST_N  in  1  asynchronous active-low reset.
REQ-005 iWR  in  1  register write strobe, one-cycle qualifier for iADDR/iDATA.
REQ-006 iADDR  in  3  register select: 0 PERIOD, 1 DEADBAND, 2 DUTY_A, 3 DUTY_B, 4 DUTY_C, 5 RAMP_STEP, 6 CTRL (bit0 RUN, bit1 FAULT_CLR); 7 ignored.
REQ-007 iDATA  in  SIZE  write data.
REQ-008 iSYNC  in  1  one-cycle pulse at PWM counter wrap (counter==0).
REQ-009 iFAULT_N  in  1  external fault, active-low, synchronous to iCLK.
REQ-010 oENABLE  out  1  PWM enable.
REQ-011 oPERIOD, oDEADBAND  out  SIZE each  active period and deadband.
REQ-012 oDUTY_A, oDUTY_B, oDUTY_C  out  SIZE each  active duties.
REQ-013 oSTATE  out  3  current state encoding; oFAULT  out  1  latched fault; oPENDING  out  1  shadow load pending.

Function
REQ-014 Writes SHALL update shadow registers only; addresses 0-5 SHALL set PENDING.
REQ-015 States SHALL be IDLE, ARMED, RAMP, RUN, FAULT.
REQ-016 IDLE: oENABLE=0, active duties 0; CTRL.RUN=1 SHALL copy shadow period/deadband to active, clear PENDING, go ARMED next cycle.
REQ-017 ARMED: oENABLE=1, duties 0; first iSYNC SHALL go RAMP.
REQ-018 RAMP: on each iSYNC each active duty SHALL move toward its clamped target by RAMP_STEP, saturating at target; when all three equal target, go RUN on that same iSYNC.
REQ-019 RAMP_STEP=0 SHALL be treated as full step (targets loaded in one iSYNC).
REQ-020 RUN: if PENDING on iSYNC, SHALL load period, deadband, duties from shadow simultaneously and clear PENDING; no active output changes between iSYNC pulses.
REQ-021 Targets SHALL clamp to active period (duty>period -> period); arithmetic SIZE+1 bits internally, no wrap.
REQ-022 CTRL.RUN=0 in ARMED/RAMP/RUN SHALL go IDLE next cycle, oENABLE=0, duties 0.
REQ-023 iFAULT_N=0 in any state SHALL, next cycle, force FAULT, oENABLE=0, duties 0, oFAULT=1; fault priority over iWR and iSYNC.
REQ-024 FAULT exits to IDLE only on CTRL.FAULT_CLR write with iFAULT_N=1; clears oFAULT; RUN must be rewritten to restart.
REQ-025 Write coinciding with iSYNC in RUN: write lands in shadow, PENDING remains set, load at next iSYNC.
REQ-026 Outputs SHALL be registered; latency iSYNC -> output change exactly 1 cycle.

Reset
REQ-027 On iRST_N low: state IDLE, oENABLE=0, all active/shadow values 0, PENDING=0, oFAULT=0, RAMP_STEP=0.
REQ-028 Reset mid-RAMP/RUN SHALL take effect immediately without waiting for iSYNC.

Structure
REQ-029 Package motor_pwm_pkg SHALL hold state encoding and register address constants.
REQ-030 One sub-module motor_pwm_ramp (single-channel saturating step toward target), instantiated three times.

Verification
REQ-031 PERIOD=100, DUTY_A/B/C=40/60/100, STEP=20, RUN -> A: 20,40; B: 20,40,60; C: 20..100; RUN after 5th iSYNC.
REQ-032 RUN, write DUTY_A=70 mid-period -> oDUTY_A unchanged until next iSYNC, then 70 one cycle later.
REQ-033 DUTY_B=150, PERIOD=100 -> oDUTY_B saturates at 100.
REQ-034 iFAULT_N low during RAMP -> next cycle oENABLE=0, duties 0, oFAULT=1; FAULT_CLR with iFAULT_N low ignored; with high -> IDLE.
REQ-035 iRST_N low in RUN -> outputs 0 asynchronously; RUN=0 -> IDLE next cycle.
